// File: rtl/mc_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | mc_ctrl_if : instruction-field, memory-handshake and datapath-control bus  |
// | between the multi-cycle controller (master) and datapath (slave).          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mc_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  fuc;
    logic        zero;
    logic        mem_ready;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ir_we;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic [1:0]  alu_op;
    logic        alu_src_b;
    logic        ext_op;
    logic        illegal;
    logic        instr_done;
    logic [31:0] retired;
    logic [3:0]  state;

    modport master (
        input  op, fuc, zero, mem_ready,
        output pc_we, pc_sel, ir_we, mem_re, mem_we, reg_we, reg_dst, wd_sel,
               alu_op, alu_src_b, ext_op, illegal, instr_done, retired, state
    );

    modport slave (
        output op, fuc, zero, mem_ready,
        input  pc_we, pc_sel, ir_we, mem_re, mem_we, reg_we, reg_dst, wd_sel,
               alu_op, alu_src_b, ext_op, illegal, instr_done, retired, state
    );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl.sv
// +----------------------------------------------------------------------------+
// | mc_ctrl : multi-cycle sequencing controller for a MIPS-subset datapath     |
// | (addu subu ori lui lw sw beq j jal jr) with ready stalls and illegal trap. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_ctrl (
    input  wire logic  clk,
    input  wire logic  reset_n,
    mc_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU = 4'd0, I_SUBU = 4'd1, I_ORI = 4'd2, I_LUI = 4'd3,
        I_LW   = 4'd4, I_SW   = 4'd5, I_BEQ = 4'd6, I_J   = 4'd7,
        I_JAL  = 4'd8, I_JR   = 4'd9, I_ILL = 4'd10
    } instr_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    state_t      state_q, state_d;
    instr_t      instr_q, instr_dec;
    logic        illegal_q;
    logic [31:0] retired_q, retired_d;

    logic        pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_b, ext_op, instr_done;
    logic [1:0]  pc_sel, reg_dst, wd_sel, alu_op;

    always_comb begin
        instr_dec = I_ILL;
        case (bus.op)
            6'b000000: begin
                case (bus.fuc)
                    6'b100001: instr_dec = I_ADDU;
                    6'b100011: instr_dec = I_SUBU;
                    6'b001000: instr_dec = I_JR;
                    default:   instr_dec = I_ILL;
                endcase
            end
            6'b100011: instr_dec = I_LW;
            6'b101011: instr_dec = I_SW;
            6'b000100: instr_dec = I_BEQ;
            6'b001111: instr_dec = I_LUI;
            6'b001101: instr_dec = I_ORI;
            6'b000010: instr_dec = I_J;
            6'b000011: instr_dec = I_JAL;
            default:   instr_dec = I_ILL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        ir_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        ext_op     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            // The live IR fields are only consulted here; later states use instr_q.
            S_DECODE: begin
                case (instr_dec)
                    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW: state_d = S_EXE;
                    I_BEQ:                                    state_d = S_BRANCH;
                    I_J, I_JAL, I_JR:                         state_d = S_JUMP;
                    default:                                  state_d = S_TRAP;
                endcase
            end
            S_EXE: begin
                state_d = S_WB;
                case (instr_q)
                    I_SUBU: alu_op = ALU_SUB;
                    I_ORI: begin
                        alu_op    = ALU_OR;
                        alu_src_b = 1'b1;
                    end
                    I_LUI: begin
                        alu_op    = ALU_LUI;
                        alu_src_b = 1'b1;
                    end
                    I_LW, I_SW: begin
                        alu_src_b = 1'b1;
                        ext_op    = 1'b1;
                        state_d   = (instr_q == I_LW) ? S_MEM_RD : S_MEM_WR;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEM_RD: begin
                mem_re = 1'b1;
                if (bus.mem_ready) state_d = S_WB;
            end
            S_MEM_WR: begin
                mem_we = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                case (instr_q)
                    I_ADDU, I_SUBU: reg_dst = 2'd1;
                    I_LW:           wd_sel  = 2'd1;
                    default:        reg_dst = 2'd0;
                endcase
            end
            S_BRANCH: begin
                alu_op     = ALU_SUB;
                pc_we      = bus.zero;
                pc_sel     = 2'd1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                case (instr_q)
                    I_JR: pc_sel = 2'd3;
                    I_JAL: begin
                        pc_sel  = 2'd2;
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                    default: pc_sel = 2'd2;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retired_q + {31'd0, instr_done};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            instr_q   <= I_ADDU;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            if (state_q == S_DECODE) instr_q <= instr_dec;
            if (state_d == S_TRAP)   illegal_q <= 1'b1;
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.pc_sel     = pc_sel;
    assign bus.ir_we      = ir_we;
    assign bus.mem_re     = mem_re;
    assign bus.mem_we     = mem_we;
    assign bus.reg_we     = reg_we;
    assign bus.reg_dst    = reg_dst;
    assign bus.wd_sel     = wd_sel;
    assign bus.alu_op     = alu_op;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_op     = ext_op;
    assign bus.instr_done = instr_done;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mc_ctrl : directed and randomized instruction sequences for mc_ctrl,    |
// | checked cycle by cycle against a per-instruction expected-trace model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mc_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if bus();

    mc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Observed control word: {illegal, state, pc_we, pc_sel, ir_we, mem_re, mem_we,
    // reg_we, reg_dst, wd_sel, alu_op, alu_src_b, ext_op, instr_done}
    localparam int F_DONE = 0,  F_EXT = 1,   F_SRCB = 2,   F_ALU = 3,  F_WD = 5, F_DST = 7;
    localparam int F_REGWE = 9, F_MEMWE = 10, F_MEMRE = 11, F_IRWE = 12;
    localparam int F_PCSEL = 13, F_PCWE = 15, F_STATE = 16, F_ILL = 20;
    localparam logic [20:0] EN_MASK = 21'h1F9E01;

    localparam logic [5:0] OPS [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                                        6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
    localparam logic [5:0] FUS [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00,
                                        6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

    logic [20:0] obs;
    assign obs = {bus.illegal, bus.state, bus.pc_we, bus.pc_sel, bus.ir_we, bus.mem_re,
                  bus.mem_we, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.alu_op,
                  bus.alu_src_b, bus.ext_op, bus.instr_done};

    typedef struct {
        logic        mr;
        logic        z;
        logic        ir_valid;
        logic [20:0] val;
        logic [20:0] care;
    } cyc_t;

    cyc_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_retired;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic string name_of(input int idx);
        case (idx)
            0: return "addu"; 1: return "subu"; 2: return "ori"; 3: return "lui";
            4: return "lw";   5: return "sw";   6: return "beq"; 7: return "j";
            8: return "jal";  default: return "jr";
        endcase
    endfunction

    function automatic cyc_t mk(input int st, input logic mr, input logic z, input logic irv);
        cyc_t c;
        logic [3:0] s4;
        s4         = st[3:0];
        c.mr       = mr;
        c.z        = z;
        c.ir_valid = irv;
        c.val      = '0;
        c.val[19:16] = s4;
        c.care     = EN_MASK;
        return c;
    endfunction

    function automatic cyc_t setf(input cyc_t c, input int lsb, input int w, input int v);
        cyc_t r;
        r = c;
        for (int i = 0; i < w; i++) begin
            r.val[lsb+i]  = v[i];
            r.care[lsb+i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    // Expected trace built straight from the per-instruction phase rules.
    task automatic build(input int idx, input int wf, input int wm, input logic z);
        cyc_t c;
        for (int i = 0; i < wf; i++) begin
            c = mk(0, 1'b0, rb(), 1'b1);
            c.care = '1;
            c = setf(c, F_MEMRE, 1, 1);
            q.push_back(c);
        end
        c = mk(0, 1'b1, rb(), 1'b1);
        c.care = '1;
        c = setf(c, F_MEMRE, 1, 1);
        c = setf(c, F_IRWE, 1, 1);
        c = setf(c, F_PCWE, 1, 1);
        q.push_back(c);
        q.push_back(mk(1, rb(), rb(), 1'b1));
        if (idx <= 5) begin
            c = mk(2, rb(), rb(), 1'b0);
            case (idx)
                0: begin c = setf(c, F_ALU, 2, 0); c = setf(c, F_SRCB, 1, 0); end
                1: begin c = setf(c, F_ALU, 2, 1); c = setf(c, F_SRCB, 1, 0); end
                2: begin c = setf(c, F_ALU, 2, 2); c = setf(c, F_SRCB, 1, 1); c = setf(c, F_EXT, 1, 0); end
                3: begin c = setf(c, F_ALU, 2, 3); c = setf(c, F_SRCB, 1, 1); c = setf(c, F_EXT, 1, 0); end
                default: begin c = setf(c, F_ALU, 2, 0); c = setf(c, F_SRCB, 1, 1); c = setf(c, F_EXT, 1, 1); end
            endcase
            q.push_back(c);
        end
        if (idx == 4 || idx == 5) begin
            for (int i = 0; i <= wm; i++) begin
                c = mk(idx == 4 ? 3 : 4, (i == wm), rb(), 1'b0);
                c = setf(c, idx == 4 ? F_MEMRE : F_MEMWE, 1, 1);
                if (idx == 5 && i == wm) c = setf(c, F_DONE, 1, 1);
                q.push_back(c);
            end
        end
        if (idx <= 4) begin
            c = mk(5, rb(), rb(), 1'b0);
            c = setf(c, F_REGWE, 1, 1);
            c = setf(c, F_DONE, 1, 1);
            c = setf(c, F_DST, 2, (idx <= 1) ? 1 : 0);
            c = setf(c, F_WD, 2, (idx == 4) ? 1 : 0);
            q.push_back(c);
        end
        if (idx == 6) begin
            c = mk(6, rb(), z, 1'b0);
            c = setf(c, F_ALU, 2, 1);
            c = setf(c, F_SRCB, 1, 0);
            c = setf(c, F_PCWE, 1, int'(z));
            c = setf(c, F_PCSEL, 2, 1);
            c = setf(c, F_DONE, 1, 1);
            q.push_back(c);
        end
        if (idx >= 7) begin
            c = mk(7, rb(), rb(), 1'b0);
            c = setf(c, F_PCWE, 1, 1);
            c = setf(c, F_DONE, 1, 1);
            c = setf(c, F_PCSEL, 2, (idx == 9) ? 3 : 2);
            if (idx == 8) begin
                c = setf(c, F_REGWE, 1, 1);
                c = setf(c, F_DST, 2, 2);
                c = setf(c, F_WD, 2, 2);
            end
            q.push_back(c);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_instr(input int idx, input int wf, input int wm, input logic z);
        cyc_t c;
        int   n;
        bus.op  = OPS[idx];
        bus.fuc = (idx <= 1 || idx == 9) ? FUS[idx] : 6'($urandom);
        build(idx, wf, wm, z);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.mem_ready = c.mr;
            bus.zero      = c.z;
            if (!c.ir_valid) begin
                bus.op  = 6'($urandom);
                bus.fuc = 6'($urandom);
            end
            #3;
            chk($sformatf("%s_cyc%0d", name_of(idx), n), {11'd0, obs & c.care}, {11'd0, c.val & c.care});
            @(posedge clk);
            #1;
            n++;
        end
        exp_retired = exp_retired + 32'd1;
        chk($sformatf("%s_retired", name_of(idx)), bus.retired, exp_retired);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {11'd0, obs}, 32'h800);
        chk("reset_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_retired = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.op = 6'd0; bus.fuc = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        exp_retired = 32'd0;
        do_reset();
        chk("post_reset_state", {28'd0, bus.state}, 32'd0);
        chk("post_reset_illegal", {31'd0, bus.illegal}, 32'd0);

        run_instr(0, 0, 0, 1'b0);
        run_instr(4, 0, 2, 1'b0);
        run_instr(5, 0, 1, 1'b0);
        run_instr(6, 0, 0, 1'b1);
        run_instr(6, 1, 0, 1'b0);
        run_instr(8, 0, 0, 1'b0);
        run_instr(9, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++)
            run_instr(int'($urandom_range(9)), int'($urandom_range(2)),
                      int'($urandom_range(2)), rb());

        // Asynchronous reset while lw waits in MEM_RD.
        bus.op = 6'h23; bus.mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b0;
        #1;
        chk("memrd_state", {28'd0, bus.state}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", {28'd0, bus.state}, 32'd0);
        chk("async_rst_ctrl", {11'd0, obs}, 32'h800);
        do_reset();

        // Illegal opcode traps and sticks.
        bus.op = 6'b111011; bus.fuc = 6'($urandom); bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("ill_decode", {28'd0, bus.state}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            bus.mem_ready = rb(); bus.zero = rb();
            bus.op = 6'($urandom); bus.fuc = 6'($urandom);
            #2;
            chk($sformatf("trap_ctrl%0d", k), {11'd0, obs}, 32'h180000);
            @(posedge clk); #1;
        end
        chk("trap_retired", bus.retired, 32'd0);
        do_reset();
        chk("trap_cleared", {31'd0, bus.illegal}, 32'd0);

        // Retired counter wrap.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("preload", bus.retired, 32'hFFFF_FFFF);
        exp_retired = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        run_instr(7, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
